// File: rtl/msk_share_encoder_pkg.sv
// Shared types and helpers for the share encoder.
// Contents: FSM state encoding and the beat-counter width helper.
package msk_share_encoder_pkg;

  // Encoder FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GATHER  = 2'd1,
    ST_COMBINE = 2'd2,
    ST_OUT     = 2'd3
  } state_e;

  // Beat counter width: clog2 of the beat count, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/msk_share_encoder_if.sv
// Stream bundle of the share encoder: word input, randomness input, sharing output.
// slave  : encoder side (consumes in/rnd, produces out)
// master : producer/consumer side (drives in/rnd, accepts out)
interface msk_share_encoder_if #(
  parameter int unsigned D  = 2,
  parameter int unsigned W  = 8,
  parameter int unsigned RW = 8
);
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [RW-1:0]  rnd;
  logic           rnd_valid;
  logic           rnd_ready;
  logic [D*W-1:0] out_shares;
  logic           out_valid;
  logic           out_ready;

  modport slave (
    input  in_data, in_valid, rnd, rnd_valid, out_ready,
    output in_ready, rnd_ready, out_shares, out_valid
  );

  modport master (
    output in_data, in_valid, rnd, rnd_valid, out_ready,
    input  in_ready, rnd_ready, out_shares, out_valid
  );
endinterface

// File: rtl/msk_share_encoder_rnd_gather.sv
// Randomness gather buffer: collects B beats of RW random bits into one register.
// clk, rst_n : clock, synchronous active-low reset
// clr_i      : zero the buffer and the beat counter
// we_i       : store rnd_i at the current beat slot and advance
// rnd_i      : random beat
// rnd_buf_o  : gathered randomness, beat b at [b*RW +: RW]
// last_c_o   : current slot is the final beat
module msk_share_encoder_rnd_gather
  import msk_share_encoder_pkg::*;
#(
  parameter int unsigned RW = 8,
  parameter int unsigned B  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            we_i,
  input  logic [RW-1:0]   rnd_i,
  output logic [RW*B-1:0] rnd_buf_o,
  output logic            last_c_o
);

  localparam int unsigned CW    = cnt_width(B);
  localparam int unsigned BUF_W = RW * B;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BUF_W-1:0] buf_q, buf_d;

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  // Slot write and counter advance; the counter holds on the last beat so it never wraps
  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (clr_i) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (we_i) begin
      for (int unsigned b = 0; b < B; b++) begin
        if (cnt_q == CW'(b)) buf_d[b*RW +: RW] = rnd_i;
      end
      if (!last_c_o) cnt_d = cnt_q + CW'(1);
    end
  end

  assign last_c_o  = (cnt_q == CW'(B - 1));
  assign rnd_buf_o = buf_q;

endmodule

// File: rtl/msk_share_encoder.sv
// Boolean share encoder: turns an unmasked W-bit word into a D-share sharing
// using (D-1)*W gathered random bits. Share i>0 is the i-th random word;
// share 0 is the word XOR all random words, computed only once all beats are in.
// clk, rst_n : clock, synchronous active-low reset
// bus        : in (word), rnd (randomness beats), out (registered sharing)
module msk_share_encoder
  import msk_share_encoder_pkg::*;
#(
  parameter int unsigned D  = 2,
  parameter int unsigned W  = 8,
  parameter int unsigned RW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  msk_share_encoder_if.slave  bus
);

  localparam int unsigned NRND = (D - 1) * W;
  localparam int unsigned B    = NRND / RW;

  // Elaboration guard on the parameter set
  if ((D < 2) || ((NRND % RW) != 0) || (B == 0)) begin : g_bad_params
    $error("msk_share_encoder: need D >= 2 and (D-1)*W a nonzero multiple of RW");
  end

  state_e           state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [D*W-1:0]   shares_q, shares_d;
  logic [NRND-1:0]  rnd_buf;
  logic             rnd_last_c;
  logic             gather_we_c;
  logic             gather_clr_c;
  logic [W-1:0]     share0_c;
  logic [D*W-1:0]   combine_c;

  msk_share_encoder_rnd_gather #(
    .RW (RW),
    .B  (B)
  ) u_gather (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (gather_clr_c),
    .we_i      (gather_we_c),
    .rnd_i     (bus.rnd),
    .rnd_buf_o (rnd_buf),
    .last_c_o  (rnd_last_c)
  );

  // State, word and sharing registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      shares_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      shares_q <= shares_d;
    end
  end

  // Share-0 XOR tree over registered operands only
  always_comb begin
    share0_c = data_q;
    for (int unsigned i = 0; i < D - 1; i++) begin
      share0_c = share0_c ^ rnd_buf[i*W +: W];
    end
  end

  // Random words land directly as shares 1..D-1
  assign combine_c = {rnd_buf, share0_c};

  // Next-state and datapath control
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    shares_d     = shares_q;
    gather_we_c  = 1'b0;
    gather_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d       = bus.in_data;
          gather_clr_c = 1'b1;
          state_d      = ST_GATHER;
        end
      end
      ST_GATHER: begin
        if (bus.rnd_valid) begin
          gather_we_c = 1'b1;
          if (rnd_last_c) state_d = ST_COMBINE;
        end
      end
      ST_COMBINE: begin
        shares_d = combine_c;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        // Scrub secrets on release; the presented sharing is left in place
        if (bus.out_ready) begin
          data_d       = '0;
          gather_clr_c = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state register
  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.rnd_ready  = (state_q == ST_GATHER);
  assign bus.out_valid  = (state_q == ST_OUT);
  assign bus.out_shares = shares_q;

endmodule

// File: tb/tb_msk_share_encoder.sv
// Directed bench for msk_share_encoder: one D=2/RW=8 and one D=3/RW=4 instance.
module tb_msk_share_encoder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  msk_share_encoder_if #(.D(2), .W(8), .RW(8)) bus2 ();
  msk_share_encoder_if #(.D(3), .W(8), .RW(4)) bus3 ();

  msk_share_encoder #(.D(2), .W(8), .RW(8)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  msk_share_encoder #(.D(3), .W(8), .RW(4)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One D=3 transaction: word din, four nibble beats, optional stall of stall_len
  // cycles once stall_at beats were delivered. Returns latency in edges from the
  // in handshake to the edge where out_valid is first seen high.
  task automatic run3(input logic [7:0] din, input logic [15:0] beats,
                      input int stall_at, input int stall_len,
                      output int lat, output int rdy_bad);
    int beat;
    int stalled;
    beat    = 0;
    stalled = 0;
    rdy_bad = 0;
    lat     = 0;
    bus3.in_data   = din;
    bus3.in_valid  = 1'b1;
    bus3.rnd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus3.in_valid = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      lat++;
      if (bus3.out_valid) break;
      if (beat < 4 && !bus3.rnd_ready) rdy_bad++;
      if (beat == stall_at && stalled < stall_len) begin
        bus3.rnd_valid = 1'b0;
        stalled++;
      end else if (beat < 4) begin
        bus3.rnd_valid = 1'b1;
        bus3.rnd       = beats[beat*4 +: 4];
        beat++;
      end else begin
        bus3.rnd_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus3.rnd_valid = 1'b0;
  endtask

  // Release the D=3 sharing and check the handshake returns to idle
  task automatic release3(input string tag, input logic [23:0] exp_shares);
    bus3.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.out_ready = 1'b0;
    check_eq({tag, "_rel_out_valid"}, 32'(bus3.out_valid), 32'd0);
    check_eq({tag, "_rel_in_ready"}, 32'(bus3.in_ready), 32'd1);
    check_eq({tag, "_rel_shares_kept"}, 32'(bus3.out_shares), 32'(exp_shares));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rdy_bad;
    int ov_seen;

    rst_n          = 1'b0;
    bus2.in_data   = '0; bus2.in_valid  = 1'b0; bus2.rnd = '0;
    bus2.rnd_valid = 1'b0; bus2.out_ready = 1'b0;
    bus3.in_data   = '0; bus3.in_valid  = 1'b0; bus3.rnd = '0;
    bus3.rnd_valid = 1'b0; bus3.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_in_ready", 32'(bus3.in_ready), 32'd1);
    check_eq("rst_rnd_ready", 32'(bus3.rnd_ready), 32'd0);
    check_eq("rst_out_valid", 32'(bus3.out_valid), 32'd0);
    check_eq("rst_shares3", 32'(bus3.out_shares), 32'd0);
    check_eq("rst_shares2", 32'(bus2.out_shares), 32'd0);

    // D=2: 0xA5 with rnd 0x3C
    bus2.in_data   = 8'hA5;
    bus2.in_valid  = 1'b1;
    bus2.rnd       = 8'h3C;
    bus2.rnd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    check_eq("d2_rnd_ready", 32'(bus2.rnd_ready), 32'd1);
    lat = 1;
    while (!bus2.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    bus2.rnd_valid = 1'b0;
    check_eq("d2_latency", 32'(lat), 32'd3);
    check_eq("d2_shares", 32'(bus2.out_shares), 32'h3C99);
    bus2.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus2.out_ready = 1'b0;
    check_eq("d2_rel_out_valid", 32'(bus2.out_valid), 32'd0);
    check_eq("d2_rel_in_ready", 32'(bus2.in_ready), 32'd1);
    check_eq("d2_rel_shares_kept", 32'(bus2.out_shares), 32'h3C99);

    // D=3: 0x00 with beats 1,2,3,4
    run3(8'h00, 16'h4321, 99, 0, lat, rdy_bad);
    check_eq("d3_latency", 32'(lat), 32'd6);
    check_eq("d3_shares", 32'(bus3.out_shares), 32'h432162);
    check_eq("d3_rnd_ready_gap", 32'(rdy_bad), 32'd0);
    release3("d3", 24'h432162);

    // Stall of three cycles between beats 2 and 3
    run3(8'h00, 16'h4321, 2, 3, lat, rdy_bad);
    check_eq("stall_latency", 32'(lat), 32'd9);
    check_eq("stall_shares", 32'(bus3.out_shares), 32'h432162);
    check_eq("stall_rnd_ready_gap", 32'(rdy_bad), 32'd0);

    // Backpressure: out_ready low for five cycles with in_valid pending
    bus3.in_data  = 8'h11;
    bus3.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_shares", 32'(bus3.out_shares), 32'h432162);
      check_eq("bp_in_ready", 32'(bus3.in_ready), 32'd0);
      check_eq("bp_out_valid", 32'(bus3.out_valid), 32'd1);
    end
    bus3.in_valid = 1'b0;
    release3("bp", 24'h432162);

    // Randomness offered in IDLE must not be consumed
    bus3.rnd       = 4'hE;
    bus3.rnd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("idle_rnd_ready", 32'(bus3.rnd_ready), 32'd0);
    end
    run3(8'h5A, 16'h4321, 99, 0, lat, rdy_bad);
    check_eq("idle_latency", 32'(lat), 32'd6);
    check_eq("idle_shares", 32'(bus3.out_shares), 32'h432138);
    release3("idle", 24'h432138);

    // Reset after the first beat discards the transaction
    bus3.in_data  = 8'h77;
    bus3.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.in_valid  = 1'b0;
    bus3.rnd       = 4'h9;
    bus3.rnd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n         = 1'b0;
    bus3.in_data  = 8'h55;
    bus3.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mrst_in_ready", 32'(bus3.in_ready), 32'd1);
    check_eq("mrst_rnd_ready", 32'(bus3.rnd_ready), 32'd0);
    check_eq("mrst_out_valid", 32'(bus3.out_valid), 32'd0);
    check_eq("mrst_shares", 32'(bus3.out_shares), 32'd0);
    check_eq("mrst_data_reg", 32'(u_dut3.data_q), 32'd0);
    check_eq("mrst_rnd_buf", 32'(u_dut3.u_gather.buf_q), 32'd0);
    check_eq("mrst_cnt", 32'(u_dut3.u_gather.cnt_q), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("mrst_hs_ignored", 32'(bus3.in_ready), 32'd1);
    check_eq("mrst_data_reg2", 32'(u_dut3.data_q), 32'd0);
    rst_n          = 1'b1;
    bus3.in_valid  = 1'b0;
    bus3.rnd_valid = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus3.out_valid) ov_seen++;
    end
    check_eq("mrst_no_out_valid", 32'(ov_seen), 32'd0);

    // Fresh transaction after reset
    run3(8'hFF, 16'hFFFF, 99, 0, lat, rdy_bad);
    check_eq("post_latency", 32'(lat), 32'd6);
    check_eq("post_shares", 32'(bus3.out_shares), 32'hFFFFFF);
    release3("post", 24'hFFFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
